alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 16-bit combinational ALU (4-bit FuncCode, operands A/B, result C) between two requesters, port 0 and port 1.
- Accepts one operation at a time through a valid/ready handshake and grants round-robin.
- Drives the shared ALU from registered operands and captures the result.
- Returns the result with the requester ID on a single response channel with valid/ready backpressure.
- Sits between the control unit and a coprocessor/DMA requester and the datapath ALU.

Parameters:
- WORD_W, 16, ALU operand/result width.
- FUNC_W, 4, ALU function-code width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 has an operation.
- req0_ready  output  1  port 0 operation accepted this cycle.
- req0_func  input  FUNC_W  port 0 ALU function code.
- req0_a  input  WORD_W  port 0 operand A.
- req0_b  input  WORD_W  port 0 operand B.
- req1_valid  input  1  port 1 has an operation.
- req1_ready  output  1  port 1 operation accepted this cycle.
- req1_func  input  FUNC_W  port 1 ALU function code.
- req1_a  input  WORD_W  port 1 operand A.
- req1_b  input  WORD_W  port 1 operand B.
- alu_a  output  WORD_W  to ALU operand A.
- alu_b  output  WORD_W  to ALU operand B.
- alu_func  output  FUNC_W  to ALU FuncCode.
- alu_c  input  WORD_W  ALU result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester that issued the result.
- rsp_data  output  WORD_W  result value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset, synchronous, with priority over all other logic:
  - state = IDLE; rr_ptr = 0 (port 0 favoured first).
  - Operand, func, ID and result registers are cleared to 0.
  - rsp_valid = 0, busy = 0, req0_ready = 0, req1_ready = 0.
  - alu_a, alu_b and alu_func are driven to 0.
  - Reset during EXEC or RESP aborts the operation; no response is issued.
- Outputs are registered state; reqN_ready is combinational from state, reqN_valid and rr_ptr.
- IDLE:
  - reqN_ready = 1 only for the granted port.
  - If only one port is valid, that port is granted.
  - If both are valid, the port equal to rr_ptr is granted.
  - On a handshake (valid && ready):
    - Latch func, a and b into the operand registers and the port number into the ID register.
    - Set rr_ptr = ~granted port.
    - Go to EXEC.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
- EXEC:
  - Exactly one cycle.
  - alu_a, alu_b and alu_func are driven from the operand registers.
  - alu_c is captured into rsp_data at the end of the cycle; go to RESP.
  - Both reqN_ready = 0.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_data are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - Both reqN_ready = 0 in RESP, so there is no overlap; peak throughput is one operation per 3 cycles.
- alu_a, alu_b and alu_func hold the last operand registers outside EXEC; there is no toggling while idle.
- Latency: the handshake in cycle N gives rsp_valid in cycle N+2 if rsp_ready is held high.
- Function codes pass through unmodified; all 16 codes are legal, and no arithmetic is done in the arbiter.
- Width rules: operands and result are WORD_W; rsp_data is exactly alu_c sampled in EXEC.
- Fairness: with both ports continuously valid, grants strictly alternate.
- Starvation: no starvation; the maximum wait is one other operation.
- A requester may change its inputs freely while not granted.
- A requester may deassert valid before its handshake with no effect.

Test Plan:
- Reset, then port 0 only: func=0000, a=0x0003, b=0x0004, rsp_ready=1 -> req0_ready=1 in IDLE; alu_func=0000 in EXEC; rsp_valid=1, rsp_id=0, rsp_data=0x0007 two cycles after the handshake.
- Both ports valid continuously:
  - Port 0: func=0010, a=0xFF00, b=0x0F0F.
  - Port 1: func=0001, a=0x0005, b=0x0007.
  - Required: grants go 0,1,0,1; responses 0x0F00 (id 0) and 0xFFFE (id 1) alternate.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with port 1 requesting func=0111, a=0x8002 -> rsp_data=0xC001 held stable; both ready signals 0; IDLE is entered only after rsp_ready=1.
- Reset asserted during EXEC (port 1, func=0100) -> next cycle state=IDLE, rsp_valid=0, rr_ptr=0; no response for the aborted operation; a new port-0 request is granted first.
- Port 1 alone after port 0 served (rr_ptr=1), then both valid -> port 1 granted immediately; next tie-break favours port 0.
- Sweep all 16 func codes from port 0 with random operands against a reference ALU model -> every rsp_data matches; busy=1 exactly from EXEC through the RESP handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requests are granted round-robin, executed from registered operands in a
// single EXEC cycle, and the captured result is returned with the requester
// ID on a valid/ready response channel.
module alu_arbiter #(
  parameter int WORD_W = 16,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [WORD_W-1:0] req0_a,
  input  logic [WORD_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [FUNC_W-1:0] req1_func,
  input  logic [WORD_W-1:0] req1_a,
  input  logic [WORD_W-1:0] req1_b,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WORD_W-1:0] alu_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [FUNC_W-1:0] op_func_q, op_func_d;
  logic [WORD_W-1:0] op_a_q, op_a_d;
  logic [WORD_W-1:0] op_b_q, op_b_d;
  logic              id_q, id_d;
  logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q;
  logic              busy_q;

  logic              gnt_vld_s;
  logic              gnt_id_s;

  // Grant selection: a lone valid port wins, a tie goes to rr_ptr; only in IDLE.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = rr_ptr_q;
      end else if (req0_valid) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b0;
      end else if (req1_valid) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b1;
      end else begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
      end
    end else begin
      gnt_vld_s = 1'b0;
      gnt_id_s  = 1'b0;
    end
  end

  assign req0_ready = gnt_vld_s && !gnt_id_s;
  assign req1_ready = gnt_vld_s &&  gnt_id_s;

  // Next-state logic: operand capture on grant, result capture in EXEC.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_func_d  = op_func_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld_s) begin
          if (gnt_id_s) begin
            op_func_d = req1_func;
            op_a_d    = req1_a;
            op_b_d    = req1_b;
          end else begin
            op_func_d = req0_func;
            op_a_d    = req0_a;
            op_b_d    = req0_b;
          end
          id_d     = gnt_id_s;
          rr_ptr_d = ~gnt_id_s;
          state_d  = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d = alu_c;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_func_q   <= {FUNC_W{1'b0}};
      op_a_q      <= {WORD_W{1'b0}};
      op_b_q      <= {WORD_W{1'b0}};
      id_q        <= 1'b0;
      rsp_data_q  <= {WORD_W{1'b0}};
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_func_q   <= op_func_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
    end
  end

  // ALU inputs come straight from the operand registers, so they hold still while idle.
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_func  = op_func_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  localparam int WORD_W = 16;
  localparam int FUNC_W = 4;

  logic              clk;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [FUNC_W-1:0] req0_func;
  logic [WORD_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [FUNC_W-1:0] req1_func;
  logic [WORD_W-1:0] req1_a, req1_b;
  logic [WORD_W-1:0] alu_a, alu_b, alu_c;
  logic [FUNC_W-1:0] alu_func;
  logic              rsp_valid, rsp_ready, rsp_id, busy;
  logic [WORD_W-1:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.WORD_W(WORD_W), .FUNC_W(FUNC_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Reference datapath ALU.
  function automatic logic [WORD_W-1:0] ref_alu(input logic [FUNC_W-1:0] f,
                                                input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b);
    case (f)
      4'd0:    ref_alu = a + b;
      4'd1:    ref_alu = a - b;
      4'd2:    ref_alu = a & b;
      4'd3:    ref_alu = a | b;
      4'd4:    ref_alu = a ^ b;
      4'd5:    ref_alu = ~a;
      4'd6:    ref_alu = a << 1;
      4'd7:    ref_alu = {a[WORD_W-1], a[WORD_W-1:1]};
      4'd8:    ref_alu = a >> 1;
      4'd9:    ref_alu = a;
      4'd10:   ref_alu = b;
      4'd11:   ref_alu = a + 16'd1;
      4'd12:   ref_alu = a - 16'd1;
      4'd13:   ref_alu = {15'd0, ($signed(a) < $signed(b))};
      4'd14:   ref_alu = ~(a & b);
      default: ref_alu = ~(a | b);
    endcase
  endfunction

  assign alu_c = ref_alu(alu_func, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_func = 4'd0; req0_a = 16'd0; req0_b = 16'd0;
    req1_valid = 1'b0; req1_func = 4'd0; req1_a = 16'd0; req1_b = 16'd0;
    rsp_ready  = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_status busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b%b expected 00", req0_ready, req1_ready);
    end
    n_checks++;
    if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_func !== 4'd0) begin
      n_fail++; $display("FAIL reset_alu got a=%h b=%h f=%h expected 0", alu_a, alu_b, alu_func);
    end
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_port0();
    req0_valid = 1'b1; req0_func = 4'b0000; req0_a = 16'h0003; req0_b = 16'h0004;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if (alu_func !== 4'b0000 || alu_a !== 16'h0003 || alu_b !== 16'h0004 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_exec got f=%h a=%h b=%h busy=%b rv=%b expected 0 0003 0004 1 0",
                         alu_func, alu_a, alu_b, busy, rsp_valid);
    end
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0007) begin
      n_fail++; $display("FAIL single_resp got v=%b id=%b d=%h expected 1 0 0007", rsp_valid, rsp_id, rsp_data);
    end
    tick(); #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_done got busy=%b rv=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic             exp_id;
    logic [WORD_W-1:0] exp_d;
    do_reset();
    req0_valid = 1'b1; req0_func = 4'b0010; req0_a = 16'hFF00; req0_b = 16'h0F0F;
    req1_valid = 1'b1; req1_func = 4'b0001; req1_a = 16'h0005; req1_b = 16'h0007;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      exp_d  = exp_id ? 16'hFFFE : 16'h0F00;
      #1;
      n_checks++;
      if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b%b expected id %0d", i, req0_ready, req1_ready, exp_id);
      end
      tick(); tick(); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_d) begin
        n_fail++; $display("FAIL rr_resp[%0d] got v=%b id=%b d=%h expected 1 %b %h",
                           i, rsp_valid, rsp_id, rsp_data, exp_id, exp_d);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    req1_valid = 1'b1; req1_func = 4'b0111; req1_a = 16'h8002; req1_b = 16'h0000;
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_grant got %b%b expected 01", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'hC001 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b id=%b d=%h rdy=%b%b busy=%b expected 1 1 c001 00 1",
                           i, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_before_ready got v=%b expected 1", rsp_valid);
    end
    tick(); #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got busy=%b v=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_exec();
    req1_valid = 1'b1; req1_func = 4'b0100; req1_a = 16'h1234; req1_b = 16'h00FF;
    rsp_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || alu_func !== 4'b0100) begin
      n_fail++; $display("FAIL rexec_in_exec got busy=%b f=%h expected 1 4", busy, alu_func);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rexec_idle got busy=%b v=%b expected 0 0", busy, rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rexec_no_resp[%0d] got v=%b expected 0", i, rsp_valid);
      end
    end
    req0_valid = 1'b1; req0_func = 4'b0000; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rexec_regrant got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0003) begin
      n_fail++; $display("FAIL rexec_resp got v=%b id=%b d=%h expected 1 0 0003", rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_rr_pointer();
    logic v0_t [5];
    logic v1_t [5];
    logic id_t [5];
    logic [WORD_W-1:0] exp_d;
    v0_t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    v1_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    id_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    req0_func = 4'd3; req0_a = 16'h00F0; req0_b = 16'h000F;
    req1_func = 4'd4; req1_a = 16'hAAAA; req1_b = 16'hFFFF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = v0_t[i]; req1_valid = v1_t[i];
      exp_d = id_t[i] ? 16'h5555 : 16'h00FF;
      #1;
      n_checks++;
      if (req0_ready !== !id_t[i] || req1_ready !== id_t[i]) begin
        n_fail++; $display("FAIL rrptr_grant[%0d] got %b%b expected id %0d", i, req0_ready, req1_ready, id_t[i]);
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== id_t[i] || rsp_data !== exp_d) begin
        n_fail++; $display("FAIL rrptr_resp[%0d] got v=%b id=%b d=%h expected 1 %b %h",
                           i, rsp_valid, rsp_id, rsp_data, id_t[i], exp_d);
      end
      tick();
    end
  endtask

  task automatic test_func_sweep();
    logic [WORD_W-1:0] a, b, exp_d, prev_a;
    prev_a = 16'h00F0;
    for (int f = 0; f < 16; f++) begin
      a = 16'($urandom); b = 16'($urandom);
      exp_d = ref_alu(4'(f), a, b);
      req0_valid = 1'b1; req0_func = 4'(f); req0_a = a; req0_b = b;
      rsp_ready = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || alu_a !== prev_a) begin
        n_fail++; $display("FAIL sweep_idle[%0d] got busy=%b alu_a=%h expected 0 %h", f, busy, alu_a, prev_a);
      end
      tick();
      req0_valid = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b1 || alu_func !== 4'(f)) begin
        n_fail++; $display("FAIL sweep_exec[%0d] got busy=%b f=%h expected 1 %h", f, busy, alu_func, f);
      end
      tick(); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || busy !== 1'b1) begin
        n_fail++; $display("FAIL sweep_data[%0d] got v=%b d=%h busy=%b expected 1 %h 1",
                           f, rsp_valid, rsp_data, busy, exp_d);
      end
      tick();
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b1 || rsp_data !== exp_d) begin
        n_fail++; $display("FAIL sweep_hold[%0d] got busy=%b d=%h expected 1 %h", f, busy, rsp_data, exp_d);
      end
      tick(); #1;
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL sweep_done[%0d] got busy=%b expected 0", f, busy);
      end
      prev_a = a;
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_single_port0();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_rr_pointer();
    test_func_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
